mem_port_arbiter: RTL

- Shares the core's single 64-bit memory port between instruction fetch (I) and load/store data access (D).
- D requests carry the write-enable and access size already produced by instruction decode.
- The block arbitrates, registers the winning request, and drives a valid/ready master port.
- For stores it generates byte strobes and lane-aligned write data. It rejects misaligned data accesses and returns a one-cycle ack to the winner.

---
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's single 64-bit memory port between instruction fetch and data access.
// Optional macro ARB_RR_EN: round-robin tie-break instead of fixed data priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,
    output logic              m_valid,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [1:0]        m_size,
    output logic [7:0]        m_strobe,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              grant_d
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RESP} state_t;

    state_t            state_reg, state_next;
    logic              resp_d_reg;
    logic              err_reg;
    logic              lane_reg;
    logic              write_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [1:0]        size_reg;
    logic [7:0]        strobe_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;

    logic              take_d;
    logic              d_misaligned;
    logic [2:0]        off;
    logic [7:0]        strobe_calc;
    logic [DATA_W-1:0] wdata_calc;

    assign off        = d_addr[2:0];
    assign wdata_calc = d_wdata << {off, 3'b000};

`ifdef ARB_RR_EN
    logic last_d_reg;

    // On a tie, the requester that was not granted last wins.
    assign take_d = d_req && (!i_req || !last_d_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_d_reg <= 1'b0;
        end else if (state_reg == IDLE) begin
            if (take_d) begin
                last_d_reg <= 1'b1;
            end else if (i_req) begin
                last_d_reg <= 1'b0;
            end
        end
    end
`else
    assign take_d = d_req;
`endif

    always_comb begin
        d_misaligned = 1'b0;
        strobe_calc  = 8'h00;
        case (d_size)
            2'd0: begin
                d_misaligned = 1'b0;
                strobe_calc  = 8'h01 << off;
            end
            2'd1: begin
                d_misaligned = d_addr[0];
                strobe_calc  = 8'h03 << off;
            end
            2'd2: begin
                d_misaligned = |d_addr[1:0];
                strobe_calc  = 8'h0F << off;
            end
            default: begin
                d_misaligned = |d_addr[2:0];
                strobe_calc  = 8'hFF;
            end
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (take_d) begin
                    state_next = d_misaligned ? RESP : SERVE_D;
                end else if (i_req) begin
                    state_next = SERVE_I;
                end
            end
            SERVE_I, SERVE_D: begin
                if (m_ready) begin
                    state_next = RESP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Payload is captured only on the grant edge so the master port stays stable under backpressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_d_reg <= 1'b0;
            err_reg    <= 1'b0;
            lane_reg   <= 1'b0;
            write_reg  <= 1'b0;
            addr_reg   <= '0;
            size_reg   <= 2'd0;
            strobe_reg <= 8'h00;
            wdata_reg  <= '0;
            rdata_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (take_d) begin
                        resp_d_reg <= 1'b1;
                        err_reg    <= d_misaligned;
                        if (!d_misaligned) begin
                            write_reg  <= d_we;
                            addr_reg   <= {d_addr[ADDR_W-1:3], 3'b000};
                            size_reg   <= d_size;
                            strobe_reg <= d_we ? strobe_calc : 8'h00;
                            wdata_reg  <= d_we ? wdata_calc : '0;
                        end
                    end else if (i_req) begin
                        resp_d_reg <= 1'b0;
                        err_reg    <= 1'b0;
                        lane_reg   <= i_addr[2];
                        write_reg  <= 1'b0;
                        addr_reg   <= {i_addr[ADDR_W-1:3], 3'b000};
                        size_reg   <= 2'd2;
                        strobe_reg <= 8'h00;
                        wdata_reg  <= '0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (m_ready) begin
                        rdata_reg <= m_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_valid  = (state_reg == SERVE_I) || (state_reg == SERVE_D);
    assign m_write  = write_reg;
    assign m_addr   = addr_reg;
    assign m_size   = size_reg;
    assign m_strobe = strobe_reg;
    assign m_wdata  = wdata_reg;
    assign i_ack    = (state_reg == RESP) && !resp_d_reg;
    assign d_ack    = (state_reg == RESP) && resp_d_reg;
    assign d_err    = d_ack && err_reg;
    assign d_rdata  = rdata_reg;
    assign i_rdata  = lane_reg ? rdata_reg[DATA_W-1:32] : rdata_reg[31:0];
    assign grant_d  = (state_reg == SERVE_D) || ((state_reg == RESP) && resp_d_reg);
endmodule
